// File: rtl/sargantana_icache_refill_ctrl.sv
// Instruction-cache refill controller.
// On a lookup miss it picks a victim way, requests the line from memory,
// waits for the response and then writes the new tag into the tag array
// for exactly one cycle. Cache flushes abort or suppress refills in flight.
//
// Configuration macro: ICACHE_PLRU_EN
//   defined   : per-set 3-bit tree-PLRU replacement, updated on hits and refills
//   undefined : single global 2-bit round-robin victim counter
//
// Ports:
//   clk_i, rstn_i                  clock, async active-low reset
//   flush_i                        cache flush pulse
//   miss_i, miss_tag_i/idx_i/vbit_i lookup miss report (sampled in IDLE)
//   hit_i, hit_way_i, hit_idx_i    lookup hit report (replacement update)
//   refill_req_o/addr_o, refill_gnt_i, refill_rsp_i  memory refill handshake
//   tag_req_o/we_o/vbit_o/data_o/addr_o              tag-array write port
//   busy_o                         controller not idle
//   done_o                         refill-complete pulse
module sargantana_icache_refill_ctrl #(
  parameter int unsigned N_WAY = 4,
  parameter int unsigned TAG_W = 27,
  parameter int unsigned IDX_W = 7
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   flush_i,
  input  logic                   miss_i,
  input  logic [TAG_W-1:0]       miss_tag_i,
  input  logic [IDX_W-1:0]       miss_idx_i,
  input  logic [N_WAY-1:0]       miss_vbit_i,
  input  logic                   hit_i,
  input  logic [1:0]             hit_way_i,
  input  logic [IDX_W-1:0]       hit_idx_i,
  output logic                   refill_req_o,
  output logic [TAG_W+IDX_W-1:0] refill_addr_o,
  input  logic                   refill_gnt_i,
  input  logic                   refill_rsp_i,
  output logic [N_WAY-1:0]       tag_req_o,
  output logic                   tag_we_o,
  output logic                   tag_vbit_o,
  output logic [TAG_W-1:0]       tag_data_o,
  output logic [IDX_W-1:0]       tag_addr_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             kill_q, kill_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       victim_q, victim_d;

  logic [1:0]       victim_sel;
  logic [1:0]       repl_victim;
  logic [N_WAY-1:0] onehot_d;
  logic             accept;
  logic             wr_commit;

  // Registered copies of the outputs
  logic              refill_req_q;
  logic [ADDR_W-1:0] refill_addr_q;
  logic [N_WAY-1:0]  tag_req_q;
  logic              tag_we_q;
  logic              tag_vbit_q;
  logic [TAG_W-1:0]  tag_data_q;
  logic [IDX_W-1:0]  tag_addr_q;
  logic              busy_q;
  logic              done_q;

  assign accept    = (state_q == S_IDLE) && miss_i && !flush_i;
  assign wr_commit = (state_q == S_WRITE) && !flush_i;

  // Victim: lowest invalid way, otherwise the replacement policy's choice
  always_comb begin
    victim_sel = repl_victim;
    for (int i = int'(N_WAY) - 1; i >= 0; i--) begin
      if (!miss_vbit_i[i]) victim_sel = 2'(i);
    end
  end

`ifdef ICACHE_PLRU_EN
  localparam int unsigned N_SET = 1 << IDX_W;

  logic [2:0] plru_q [N_SET];
  logic [2:0] plru_miss;

  // Bits point away from the most recently touched way
  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r    = b;
    r[0] = ~w[1];
    if (w[1]) r[2] = ~w[0];
    else      r[1] = ~w[0];
    return r;
  endfunction

  assign plru_miss   = plru_q[miss_idx_i];
  assign repl_victim = plru_miss[0] ? (plru_miss[2] ? 2'd3 : 2'd2)
                                    : (plru_miss[1] ? 2'd1 : 2'd0);

  // PLRU state; a refill write wins over a hit to the same set
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < int'(N_SET); s++) plru_q[s] <= 3'd0;
    end else if (flush_i) begin
      for (int s = 0; s < int'(N_SET); s++) plru_q[s] <= 3'd0;
    end else begin
      if (hit_i && !(wr_commit && (hit_idx_i == idx_q)))
        plru_q[hit_idx_i] <= plru_touch(plru_q[hit_idx_i], hit_way_i);
      if (wr_commit)
        plru_q[idx_q] <= plru_touch(plru_q[idx_q], victim_q);
    end
  end
`else
  logic [1:0] rr_q;
  logic       all_valid_q;
  logic       unused_hit;

  assign repl_victim = rr_q;
  assign unused_hit  = ^{hit_i, hit_way_i, hit_idx_i};

  // Round-robin advances only when a valid line was evicted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_q        <= 2'd0;
      all_valid_q <= 1'b0;
    end else if (flush_i) begin
      rr_q        <= 2'd0;
      all_valid_q <= 1'b0;
    end else begin
      if (accept) all_valid_q <= &miss_vbit_i;
      if (wr_commit && all_valid_q) rr_q <= rr_q + 2'd1;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    victim_d = victim_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_REQ;
          tag_d    = miss_tag_i;
          idx_d    = miss_idx_i;
          victim_d = victim_sel;
        end
      end
      S_REQ: begin
        if (flush_i)           state_d = S_IDLE;
        else if (refill_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A flush seen while waiting kills the write once the response lands
        if (refill_rsp_i) begin
          state_d = (kill_q || flush_i) ? S_IDLE : S_WRITE;
          kill_d  = 1'b0;
        end else if (flush_i) begin
          kill_d  = 1'b1;
        end
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    onehot_d           = '0;
    onehot_d[victim_d] = 1'b1;
  end

  // State and output registers; outputs follow the next state
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      kill_q        <= 1'b0;
      tag_q         <= '0;
      idx_q         <= '0;
      victim_q      <= 2'd0;
      refill_req_q  <= 1'b0;
      refill_addr_q <= '0;
      tag_req_q     <= '0;
      tag_we_q      <= 1'b0;
      tag_vbit_q    <= 1'b0;
      tag_data_q    <= '0;
      tag_addr_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      kill_q        <= kill_d;
      tag_q         <= tag_d;
      idx_q         <= idx_d;
      victim_q      <= victim_d;
      refill_req_q  <= (state_d == S_REQ);
      refill_addr_q <= (state_d == S_REQ) ? {tag_d, idx_d} : '0;
      tag_req_q     <= (state_d == S_WRITE) ? onehot_d : '0;
      tag_we_q      <= (state_d == S_WRITE);
      tag_vbit_q    <= (state_d == S_WRITE);
      tag_data_q    <= (state_d == S_WRITE) ? tag_d : '0;
      tag_addr_q    <= (state_d == S_WRITE) ? idx_d : '0;
      busy_q        <= (state_d != S_IDLE);
      done_q        <= (state_d == S_WRITE);
    end
  end

  assign refill_req_o  = refill_req_q;
  assign refill_addr_o = refill_addr_q;
  assign tag_vbit_o    = tag_vbit_q;
  assign tag_data_o    = tag_data_q;
  assign tag_addr_o    = tag_addr_q;
  assign busy_o        = busy_q;
  // A flush landing in the write cycle must not re-validate a line the
  // tag array is clearing in that same cycle, so the strobes are gated live.
  assign tag_req_o     = tag_req_q & ~{N_WAY{flush_i}};
  assign tag_we_o      = tag_we_q & ~flush_i;
  assign done_o        = done_q & ~flush_i;

endmodule

// File: tb/tb_sargantana_icache_refill_ctrl.sv
// Directed testbench for sargantana_icache_refill_ctrl.
// Ports: none (drives the DUT clock, reset and all inputs).
// Build-time macro ICACHE_PLRU_EN selects the replacement-policy test.
module tb_sargantana_icache_refill_ctrl;

  localparam int unsigned N_WAY  = 4;
  localparam int unsigned TAG_W  = 27;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              flush_i;
  logic              miss_i;
  logic [TAG_W-1:0]  miss_tag_i;
  logic [IDX_W-1:0]  miss_idx_i;
  logic [N_WAY-1:0]  miss_vbit_i;
  logic              hit_i;
  logic [1:0]        hit_way_i;
  logic [IDX_W-1:0]  hit_idx_i;
  logic              refill_req_o;
  logic [ADDR_W-1:0] refill_addr_o;
  logic              refill_gnt_i;
  logic              refill_rsp_i;
  logic [N_WAY-1:0]  tag_req_o;
  logic              tag_we_o;
  logic              tag_vbit_o;
  logic [TAG_W-1:0]  tag_data_o;
  logic [IDX_W-1:0]  tag_addr_o;
  logic              busy_o;
  logic              done_o;

  int errors = 0;
  int checks = 0;

  sargantana_icache_refill_ctrl #(
    .N_WAY(N_WAY), .TAG_W(TAG_W), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .miss_i(miss_i), .miss_tag_i(miss_tag_i), .miss_idx_i(miss_idx_i),
    .miss_vbit_i(miss_vbit_i),
    .hit_i(hit_i), .hit_way_i(hit_way_i), .hit_idx_i(hit_idx_i),
    .refill_req_o(refill_req_o), .refill_addr_o(refill_addr_o),
    .refill_gnt_i(refill_gnt_i), .refill_rsp_i(refill_rsp_i),
    .tag_req_o(tag_req_o), .tag_we_o(tag_we_o), .tag_vbit_o(tag_vbit_o),
    .tag_data_o(tag_data_o), .tag_addr_o(tag_addr_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; outputs settle 1 ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present a miss for one cycle; afterwards the DUT is in REQ
  task automatic do_miss(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                         input logic [N_WAY-1:0] vb);
    miss_i = 1'b1; miss_tag_i = t; miss_idx_i = ix; miss_vbit_i = vb;
    tick();
    miss_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    #1;
    checks++;
    if ({refill_req_o, refill_addr_o, tag_req_o, tag_we_o, tag_vbit_o, tag_data_o,
         tag_addr_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b addr=%h treq=%b we=%b busy=%b done=%b expected all 0",
               refill_req_o, refill_addr_o, tag_req_o, tag_we_o, busy_o, done_o);
    end
    tick(); tick();
    rstn_i = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o);
    end
  endtask

  task automatic test_basic();
    do_miss(27'h1234, 7'd5, 4'b0000);
    checks++;
    if (refill_req_o !== 1'b1 || refill_addr_o !== {27'h1234, 7'd5} || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_req: got req=%b addr=%h busy=%b expected 1 %h 1",
               refill_req_o, refill_addr_o, busy_o, {27'h1234, 7'd5});
    end
    refill_gnt_i = 1'b1;
    tick();
    refill_gnt_i = 1'b0;
    checks++;
    if (refill_req_o !== 1'b0 || tag_we_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_wait: got req=%b we=%b busy=%b expected 0 0 1", refill_req_o, tag_we_o, busy_o);
    end
    refill_rsp_i = 1'b1;
    tick();
    refill_rsp_i = 1'b0;
    checks++;
    if (tag_req_o !== 4'b0001 || tag_we_o !== 1'b1 || tag_vbit_o !== 1'b1 ||
        tag_data_o !== 27'h1234 || tag_addr_o !== 7'd5 || done_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_write: got treq=%b we=%b vbit=%b data=%h addr=%h done=%b expected 0001 1 1 1234 05 1",
               tag_req_o, tag_we_o, tag_vbit_o, tag_data_o, tag_addr_o, done_o);
    end
    tick();
    checks++;
    if (tag_req_o !== 4'b0000 || tag_we_o !== 1'b0 || done_o !== 1'b0 ||
        tag_data_o !== '0 || tag_addr_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_after: got treq=%b we=%b done=%b data=%h busy=%b expected all 0",
               tag_req_o, tag_we_o, done_o, tag_data_o, busy_o);
    end
  endtask

  task automatic test_victim_stall();
    do_miss(27'h0ABC, 7'h11, 4'b1011);
    // A second miss while busy must be ignored
    miss_i = 1'b1; miss_tag_i = 27'h7FF; miss_idx_i = 7'd3; miss_vbit_i = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (refill_req_o !== 1'b1 || refill_addr_o !== {27'h0ABC, 7'h11}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got req=%b addr=%h expected 1 %h",
                 c, refill_req_o, refill_addr_o, {27'h0ABC, 7'h11});
      end
      tick();
    end
    miss_i = 1'b0;
    refill_gnt_i = 1'b1;
    tick();
    refill_gnt_i = 1'b0;
    refill_rsp_i = 1'b1;
    tick();
    refill_rsp_i = 1'b0;
    checks++;
    if (tag_req_o !== 4'b0100 || tag_data_o !== 27'h0ABC || tag_addr_o !== 7'h11) begin
      errors++;
      $display("FAIL stall_victim: got treq=%b data=%h addr=%h expected 0100 0abc 11",
               tag_req_o, tag_data_o, tag_addr_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || refill_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_ignored_miss: got busy=%b req=%b expected 0 0", busy_o, refill_req_o);
    end
  endtask

`ifdef ICACHE_PLRU_EN
  task automatic test_plru();
    flush_i = 1'b1; tick(); flush_i = 1'b0;
    hit_i = 1'b1; hit_idx_i = 7'd9;
    hit_way_i = 2'd0; tick();
    hit_way_i = 2'd2; tick();
    hit_i = 1'b0;
    do_miss(27'h99, 7'd9, 4'b1111);
    refill_gnt_i = 1'b1; tick(); refill_gnt_i = 1'b0;
    refill_rsp_i = 1'b1; tick(); refill_rsp_i = 1'b0;
    checks++;
    if (tag_req_o !== 4'b0010) begin
      errors++;
      $display("FAIL plru_victim: got treq=%b expected 0010", tag_req_o);
    end
    tick();
  endtask
`else
  task automatic test_round_robin();
    logic [3:0] exp_req [5];
    exp_req[0] = 4'b0001; exp_req[1] = 4'b0010; exp_req[2] = 4'b0100;
    exp_req[3] = 4'b1000; exp_req[4] = 4'b0001;
    // Hits have no effect on the round-robin counter
    hit_i = 1'b1; hit_way_i = 2'd3; hit_idx_i = 7'd20;
    for (int n = 0; n < 5; n++) begin
      do_miss(27'(32'h200 + 32'(n)), 7'd20, 4'b1111);
      refill_gnt_i = 1'b1; tick(); refill_gnt_i = 1'b0;
      refill_rsp_i = 1'b1; tick(); refill_rsp_i = 1'b0;
      checks++;
      if (tag_req_o !== exp_req[n]) begin
        errors++;
        $display("FAIL rr_victim miss %0d: got treq=%b expected %b", n, tag_req_o, exp_req[n]);
      end
      tick();
    end
    hit_i = 1'b0;
  endtask
`endif

  task automatic test_flush_idle();
    miss_i = 1'b1; flush_i = 1'b1;
    miss_tag_i = 27'h44; miss_idx_i = 7'd2; miss_vbit_i = 4'b0000;
    tick();
    miss_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || refill_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b req=%b expected 0 0", busy_o, refill_req_o);
    end
  endtask

  task automatic test_flush_req();
    do_miss(27'h55, 7'd2, 4'b0000);
    refill_gnt_i = 1'b1; flush_i = 1'b1;
    tick();
    refill_gnt_i = 1'b0; flush_i = 1'b0;
    checks++;
    if (refill_req_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_req: got req=%b busy=%b expected 0 0", refill_req_o, busy_o);
    end
    refill_rsp_i = 1'b1; tick(); refill_rsp_i = 1'b0;
    checks++;
    if (tag_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_rsp: got we=%b done=%b busy=%b expected 0 0 0", tag_we_o, done_o, busy_o);
    end
  endtask

  task automatic test_flush_wait();
    do_miss(27'h66, 7'd4, 4'b0000);
    refill_gnt_i = 1'b1; tick(); refill_gnt_i = 1'b0;
    flush_i = 1'b1;
    miss_i = 1'b1; miss_tag_i = 27'h123; miss_idx_i = 7'd8; miss_vbit_i = 4'b0000;
    tick();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || tag_we_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_hold: got busy=%b we=%b expected 1 0", busy_o, tag_we_o);
    end
    tick();
    refill_rsp_i = 1'b1;
    tick();
    refill_rsp_i = 1'b0; miss_i = 1'b0;
    checks++;
    if (tag_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0 || tag_req_o !== 4'b0000) begin
      errors++;
      $display("FAIL flush_wait_rsp: got we=%b done=%b busy=%b treq=%b expected 0 0 0 0000",
               tag_we_o, done_o, busy_o, tag_req_o);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0 || tag_we_o !== 1'b0 || refill_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_after: got busy=%b we=%b req=%b expected 0 0 0", busy_o, tag_we_o, refill_req_o);
    end
  endtask

  task automatic test_flush_write();
    do_miss(27'h77, 7'd6, 4'b0000);
    refill_gnt_i = 1'b1; tick(); refill_gnt_i = 1'b0;
    refill_rsp_i = 1'b1; tick(); refill_rsp_i = 1'b0;
    checks++;
    if (tag_we_o !== 1'b1 || tag_data_o !== 27'h77) begin
      errors++;
      $display("FAIL flush_write_pre: got we=%b data=%h expected 1 77", tag_we_o, tag_data_o);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (tag_we_o !== 1'b0 || done_o !== 1'b0 || tag_req_o !== 4'b0000) begin
      errors++;
      $display("FAIL flush_write_gate: got we=%b done=%b treq=%b expected 0 0 0000", tag_we_o, done_o, tag_req_o);
    end
    tick();
    flush_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_write_after: got busy=%b done=%b expected 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_reset_wait();
    do_miss(27'h88, 7'd1, 4'b0000);
    refill_gnt_i = 1'b1; tick(); refill_gnt_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++; $display("FAIL reset_wait_pre: got busy=%b expected 1", busy_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if ({refill_req_o, refill_addr_o, tag_req_o, tag_we_o, tag_vbit_o, tag_data_o,
         tag_addr_o, busy_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset_wait_async: got req=%b busy=%b we=%b done=%b expected all 0",
               refill_req_o, busy_o, tag_we_o, done_o);
    end
    #2 rstn_i = 1'b1;
    refill_rsp_i = 1'b1;
    tick(); tick();
    refill_rsp_i = 1'b0;
    checks++;
    if (tag_we_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_rsp: got we=%b done=%b busy=%b expected 0 0 0", tag_we_o, done_o, busy_o);
    end
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0; miss_i = 1'b0;
    miss_tag_i = '0; miss_idx_i = '0; miss_vbit_i = '0;
    hit_i = 1'b0; hit_way_i = 2'd0; hit_idx_i = '0;
    refill_gnt_i = 1'b0; refill_rsp_i = 1'b0;

    test_reset();
    test_basic();
    test_victim_stall();
`ifdef ICACHE_PLRU_EN
    test_plru();
`else
    test_round_robin();
`endif
    test_flush_idle();
    test_flush_req();
    test_flush_wait();
    test_flush_write();
    test_reset_wait();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
